// File: rtl/nios_simple_pixel_stream_arbiter.sv
// Packet-aware 2:1 Avalon-ST arbiter: round-robin grant at packet boundaries, held SOP..EOP,
// with per-source completed-packet counters and a sticky framing-error flag.
module nios_simple_pixel_stream_arbiter #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned EMPTY_WIDTH = 2,
  parameter int unsigned CNT_WIDTH   = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in0_valid,
  output logic                   in0_ready,
  input  logic [DATA_WIDTH-1:0]  in0_data,
  input  logic                   in0_startofpacket,
  input  logic                   in0_endofpacket,
  input  logic [EMPTY_WIDTH-1:0] in0_empty,
  input  logic                   in1_valid,
  output logic                   in1_ready,
  input  logic [DATA_WIDTH-1:0]  in1_data,
  input  logic                   in1_startofpacket,
  input  logic                   in1_endofpacket,
  input  logic [EMPTY_WIDTH-1:0] in1_empty,
  input  logic                   out_ready,
  output logic                   out_valid,
  output logic [DATA_WIDTH-1:0]  out_data,
  output logic                   out_startofpacket,
  output logic                   out_endofpacket,
  output logic [EMPTY_WIDTH-1:0] out_empty,
  output logic [1:0]             grant,
  output logic [CNT_WIDTH-1:0]   pkt_count0,
  output logic [CNT_WIDTH-1:0]   pkt_count1,
  output logic                   framing_err,
  input  logic                   clear_status
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] OWN0 = 2'd1;
  localparam logic [1:0] OWN1 = 2'd2;

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic       last_owner;
  logic       elig0, elig1;
  logic       stray0, stray1;
  logic       done0, done1;
  logic       stray;

  always_comb begin
    elig0  = in0_valid & in0_startofpacket;
    elig1  = in1_valid & in1_startofpacket;
    stray0 = in0_valid & ~in0_startofpacket;
    stray1 = in1_valid & ~in1_startofpacket;
    done0  = (state == OWN0) & in0_valid & out_ready & in0_endofpacket;
    done1  = (state == OWN1) & in1_valid & out_ready & in1_endofpacket;
    stray  = (state == IDLE) & (stray0 | stray1);
  end

  // Datapath and handshakes are purely combinational from the registered owner.
  always_comb begin
    out_valid         = 1'b0;
    out_data          = '0;
    out_startofpacket = 1'b0;
    out_endofpacket   = 1'b0;
    out_empty         = '0;
    in0_ready         = 1'b0;
    in1_ready         = 1'b0;
    grant             = 2'b00;
    case (state)
      IDLE: begin
        // Non-SOP beats are swallowed while idle; SOP beats wait for the grant.
        in0_ready = stray0;
        in1_ready = stray1;
      end
      OWN0: begin
        out_valid         = in0_valid;
        out_data          = in0_data;
        out_startofpacket = in0_startofpacket;
        out_endofpacket   = in0_endofpacket;
        out_empty         = in0_empty;
        in0_ready         = out_ready;
        grant             = 2'b01;
      end
      OWN1: begin
        out_valid         = in1_valid;
        out_data          = in1_data;
        out_startofpacket = in1_startofpacket;
        out_endofpacket   = in1_endofpacket;
        out_empty         = in1_empty;
        in1_ready         = out_ready;
        grant             = 2'b10;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (elig0 && elig1) state_nxt = last_owner ? OWN0 : OWN1;
        else if (elig0)     state_nxt = OWN0;
        else if (elig1)     state_nxt = OWN1;
      end
      OWN0:    if (done0) state_nxt = IDLE;
      OWN1:    if (done1) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      last_owner <= 1'b1;
    end else begin
      state <= state_nxt;
      if (done0) last_owner <= 1'b0;
      if (done1) last_owner <= 1'b1;
    end
  end

  // Clear beats a same-cycle increment, but a same-cycle framing error still sticks.
  always_ff @(posedge clk) begin
    if (reset || clear_status) begin
      pkt_count0 <= '0;
      pkt_count1 <= '0;
    end else begin
      if (done0) pkt_count0 <= pkt_count0 + CNT_WIDTH'(1);
      if (done1) pkt_count1 <= pkt_count1 + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset)             framing_err <= 1'b0;
    else if (stray)        framing_err <= 1'b1;
    else if (clear_status) framing_err <= 1'b0;
  end

endmodule

// File: tb/tb_nios_simple_pixel_stream_arbiter.sv
// Randomized bench for nios_simple_pixel_stream_arbiter: per-source beat queues feed the DUT and a
// packet-level ownership model predicts handshakes, output beats, grant order and status each cycle.
module tb_nios_simple_pixel_stream_arbiter;

  typedef struct packed {
    logic [31:0] data;
    logic        sop;
    logic        eop;
    logic [1:0]  empty;
  } beat_t;

  logic        clk;
  logic        reset;
  logic        in0_valid, in0_ready, in0_startofpacket, in0_endofpacket;
  logic [31:0] in0_data;
  logic [1:0]  in0_empty;
  logic        in1_valid, in1_ready, in1_startofpacket, in1_endofpacket;
  logic [31:0] in1_data;
  logic [1:0]  in1_empty;
  logic        out_ready, out_valid, out_startofpacket, out_endofpacket;
  logic [31:0] out_data;
  logic [1:0]  out_empty;
  logic [1:0]  grant;
  logic [15:0] pkt_count0, pkt_count1;
  logic        framing_err;
  logic        clear_status;

  nios_simple_pixel_stream_arbiter #(
    .DATA_WIDTH (32),
    .EMPTY_WIDTH(2),
    .CNT_WIDTH  (16)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .in0_valid        (in0_valid),
    .in0_ready        (in0_ready),
    .in0_data         (in0_data),
    .in0_startofpacket(in0_startofpacket),
    .in0_endofpacket  (in0_endofpacket),
    .in0_empty        (in0_empty),
    .in1_valid        (in1_valid),
    .in1_ready        (in1_ready),
    .in1_data         (in1_data),
    .in1_startofpacket(in1_startofpacket),
    .in1_endofpacket  (in1_endofpacket),
    .in1_empty        (in1_empty),
    .out_ready        (out_ready),
    .out_valid        (out_valid),
    .out_data         (out_data),
    .out_startofpacket(out_startofpacket),
    .out_endofpacket  (out_endofpacket),
    .out_empty        (out_empty),
    .grant            (grant),
    .pkt_count0       (pkt_count0),
    .pkt_count1       (pkt_count1),
    .framing_err      (framing_err),
    .clear_status     (clear_status)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  beat_t       q0[$];
  beat_t       q1[$];
  logic        rdy_q[$];
  logic [1:0]  glog[$];
  logic [1:0]  prev_grant;
  int          gap_pct, stall_pct;
  logic        rst_req, clr_req, chk_en;
  int          m_owner;  // -1 idle, else owning source
  logic        m_last;
  logic [15:0] m_cnt0, m_cnt1;
  logic        m_ferr;
  int          errs, checks;

  task automatic add_pkt(input int src, input int len, input bit junk);
    beat_t b;
    if (junk) begin
      b = '{data: $urandom, sop: 1'b0, eop: 1'b0, empty: 2'd0};
      if (src == 0) q0.push_back(b); else q1.push_back(b);
    end
    for (int i = 0; i < len; i++) begin
      b.data  = $urandom;
      b.sop   = (i == 0);
      b.eop   = (i == len - 1);
      b.empty = (i == len - 1) ? 2'($urandom_range(0, 3)) : 2'd0;
      if (src == 0) q0.push_back(b); else q1.push_back(b);
    end
  endtask

  // One clock: drive sources from queue heads, compare the DUT with the model, advance both.
  task automatic step();
    beat_t b0, b1, eb;
    logic  ev, er0, er1, nerr, e0, e1;
    logic [1:0] eg;
    b0 = (q0.size() != 0) ? q0[0] : '0;
    b1 = (q1.size() != 0) ? q1[0] : '0;
    in0_valid = (q0.size() != 0) && ($urandom_range(0, 99) >= gap_pct);
    in1_valid = (q1.size() != 0) && ($urandom_range(0, 99) >= gap_pct);
    {in0_data, in0_startofpacket, in0_endofpacket, in0_empty} = b0;
    {in1_data, in1_startofpacket, in1_endofpacket, in1_empty} = b1;
    if (rdy_q.size() != 0) out_ready = rdy_q.pop_front();
    else out_ready = ($urandom_range(0, 99) >= stall_pct);
    reset        = rst_req;
    clear_status = clr_req;
    @(negedge clk);
    ev = 1'b0; er0 = 1'b0; er1 = 1'b0; eg = 2'b00; eb = '0;
    if (m_owner < 0) begin
      er0 = in0_valid & ~b0.sop;
      er1 = in1_valid & ~b1.sop;
    end else if (m_owner == 0) begin
      ev = in0_valid; eb = b0; er0 = out_ready; eg = 2'b01;
    end else begin
      ev = in1_valid; eb = b1; er1 = out_ready; eg = 2'b10;
    end
    if (chk_en) begin
      checks++;
      if (out_valid !== ev) begin errs++; $display("FAIL out_valid t=%0t got=%b exp=%b", $time, out_valid, ev); end
      checks++;
      if (grant !== eg) begin errs++; $display("FAIL grant t=%0t got=%b exp=%b", $time, grant, eg); end
      checks++;
      if (in0_ready !== er0) begin errs++; $display("FAIL in0_ready t=%0t got=%b exp=%b", $time, in0_ready, er0); end
      checks++;
      if (in1_ready !== er1) begin errs++; $display("FAIL in1_ready t=%0t got=%b exp=%b", $time, in1_ready, er1); end
      checks++;
      if (pkt_count0 !== m_cnt0) begin errs++; $display("FAIL pkt_count0 t=%0t got=%0d exp=%0d", $time, pkt_count0, m_cnt0); end
      checks++;
      if (pkt_count1 !== m_cnt1) begin errs++; $display("FAIL pkt_count1 t=%0t got=%0d exp=%0d", $time, pkt_count1, m_cnt1); end
      checks++;
      if (framing_err !== m_ferr) begin errs++; $display("FAIL framing_err t=%0t got=%b exp=%b", $time, framing_err, m_ferr); end
      if (ev) begin
        checks++;
        if ({out_data, out_startofpacket, out_endofpacket, out_empty} !== eb) begin
          errs++;
          $display("FAIL out_beat t=%0t got=%h/%b/%b/%0d exp=%h/%b/%b/%0d", $time, out_data,
                   out_startofpacket, out_endofpacket, out_empty, eb.data, eb.sop, eb.eop, eb.empty);
        end
      end
    end
    if (grant != 2'b00 && grant != prev_grant) glog.push_back(grant);
    prev_grant = grant;
    if (rst_req) begin
      m_owner = -1; m_last = 1'b1; m_cnt0 = '0; m_cnt1 = '0; m_ferr = 1'b0;
    end else begin
      nerr = (m_owner < 0) && (er0 || er1);
      if (m_owner < 0) begin
        e0 = in0_valid & b0.sop;
        e1 = in1_valid & b1.sop;
        if (e0 && e1) m_owner = m_last ? 0 : 1;
        else if (e0)  m_owner = 0;
        else if (e1)  m_owner = 1;
      end else if (m_owner == 0 && in0_valid && out_ready && b0.eop) begin
        m_owner = -1; m_last = 1'b0; m_cnt0 = m_cnt0 + 16'd1;
      end else if (m_owner == 1 && in1_valid && out_ready && b1.eop) begin
        m_owner = -1; m_last = 1'b1; m_cnt1 = m_cnt1 + 16'd1;
      end
      if (clr_req) begin m_cnt0 = '0; m_cnt1 = '0; m_ferr = nerr; end
      else m_ferr = m_ferr | nerr;
    end
    @(posedge clk);
    #1;
    if (in0_valid && er0 && q0.size() != 0) void'(q0.pop_front());
    if (in1_valid && er1 && q1.size() != 0) void'(q1.pop_front());
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((q0.size() != 0 || q1.size() != 0 || m_owner >= 0) && n < 5000) begin
      step();
      n++;
    end
    checks++;
    if (n >= 5000) begin errs++; $display("FAIL %s_timeout got=%0d cycles exp<5000", name, n); end
  endtask

  task automatic test_reset();
    chk_en = 1'b0; rst_req = 1'b1;
    step(); step();
    rst_req = 1'b0; chk_en = 1'b1;
    checks++;
    if (grant !== 2'b00 || out_valid !== 1'b0 || in0_ready !== 1'b0 || in1_ready !== 1'b0) begin
      errs++; $display("FAIL reset_outputs got grant=%b ov=%b r0=%b r1=%b exp 00/0/0/0", grant, out_valid, in0_ready, in1_ready);
    end
    checks++;
    if (pkt_count0 !== 16'd0 || pkt_count1 !== 16'd0 || framing_err !== 1'b0) begin
      errs++; $display("FAIL reset_status got c0=%0d c1=%0d fe=%b exp 0/0/0", pkt_count0, pkt_count1, framing_err);
    end
    step();
  endtask

  task automatic test_single_packet();
    gap_pct = 0; stall_pct = 0; glog.delete();
    add_pkt(0, 4, 1'b0);
    drain("single");
    checks++;
    if (pkt_count0 !== 16'd1) begin errs++; $display("FAIL single_count got=%0d exp=1", pkt_count0); end
    checks++;
    if (glog.size() != 1 || glog[0] !== 2'b01) begin errs++; $display("FAIL single_grant got n=%0d exp one 01 grant", glog.size()); end
  endtask

  task automatic test_round_robin();
    rst_req = 1'b1; step(); rst_req = 1'b0;
    glog.delete();
    add_pkt(0, 3, 1'b0); add_pkt(0, 2, 1'b0);
    add_pkt(1, 2, 1'b0); add_pkt(1, 1, 1'b0);
    drain("rr");
    checks++;
    if (glog.size() != 4 || glog[0] !== 2'b01 || glog[1] !== 2'b10 || glog[2] !== 2'b01 || glog[3] !== 2'b10) begin
      errs++; $display("FAIL rr_order got n=%0d exp 01,10,01,10", glog.size());
    end
    checks++;
    if (pkt_count0 !== 16'd2 || pkt_count1 !== 16'd2) begin
      errs++; $display("FAIL rr_counts got=%0d/%0d exp=2/2", pkt_count0, pkt_count1);
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] c1;
    c1 = m_cnt1;
    add_pkt(1, 3, 1'b0);
    rdy_q = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    stall_pct = 0;
    drain("bp");
    checks++;
    if (pkt_count1 !== c1 + 16'd1) begin errs++; $display("FAIL bp_count got=%0d exp=%0d", pkt_count1, c1 + 16'd1); end
  endtask

  task automatic test_framing();
    add_pkt(0, 0, 1'b1);
    drain("framing");
    checks++;
    if (framing_err !== 1'b1) begin errs++; $display("FAIL framing_set got=%b exp=1", framing_err); end
    clr_req = 1'b1; step(); clr_req = 1'b0;
    checks++;
    if (framing_err !== 1'b0 || pkt_count0 !== 16'd0 || pkt_count1 !== 16'd0) begin
      errs++; $display("FAIL clear got fe=%b c0=%0d c1=%0d exp 0/0/0", framing_err, pkt_count0, pkt_count1);
    end
  endtask

  task automatic test_reset_mid_packet();
    gap_pct = 0; stall_pct = 0;
    add_pkt(0, 1, 1'b0);
    drain("pre_reset");
    add_pkt(0, 5, 1'b0);
    step(); step();
    rst_req = 1'b1; step(); rst_req = 1'b0;
    q0.delete();
    checks++;
    if (grant !== 2'b00 || pkt_count0 !== 16'd0 || out_valid !== 1'b0) begin
      errs++; $display("FAIL midreset got grant=%b c0=%0d ov=%b exp 00/0/0", grant, pkt_count0, out_valid);
    end
    glog.delete();
    add_pkt(1, 2, 1'b0);
    drain("post_reset");
    checks++;
    if (glog.size() != 1 || glog[0] !== 2'b10 || pkt_count1 !== 16'd1 || pkt_count0 !== 16'd0) begin
      errs++; $display("FAIL post_reset got n=%0d c0=%0d c1=%0d exp one 10 grant, 0/1", glog.size(), pkt_count0, pkt_count1);
    end
  endtask

  task automatic test_wrap();
    force dut.pkt_count1 = 16'hFFFF;
    #1;
    release dut.pkt_count1;
    m_cnt1 = 16'hFFFF;
    add_pkt(1, 1, 1'b0);
    drain("wrap");
    checks++;
    if (pkt_count1 !== 16'h0000) begin errs++; $display("FAIL wrap got=%h exp=0000", pkt_count1); end
  endtask

  task automatic test_random();
    gap_pct = 25; stall_pct = 30;
    for (int c = 0; c < 4000; c++) begin
      if (q0.size() < 4 && $urandom_range(0, 3) == 0) add_pkt(0, $urandom_range(1, 6), $urandom_range(0, 9) == 0);
      if (q1.size() < 4 && $urandom_range(0, 3) == 0) add_pkt(1, $urandom_range(1, 6), $urandom_range(0, 9) == 0);
      clr_req = ($urandom_range(0, 49) == 0);
      step();
    end
    clr_req = 1'b0;
    drain("random");
  endtask

  initial begin
    errs = 0; checks = 0;
    gap_pct = 0; stall_pct = 0;
    rst_req = 1'b0; clr_req = 1'b0; chk_en = 1'b0;
    m_owner = -1; m_last = 1'b1; m_cnt0 = '0; m_cnt1 = '0; m_ferr = 1'b0;
    prev_grant = 2'b00;
    reset = 1'b1; clear_status = 1'b0; out_ready = 1'b0;
    in0_valid = 1'b0; in0_data = '0; in0_startofpacket = 1'b0; in0_endofpacket = 1'b0; in0_empty = '0;
    in1_valid = 1'b0; in1_data = '0; in1_startofpacket = 1'b0; in1_endofpacket = 1'b0; in1_empty = '0;
    @(posedge clk);
    #1;
    test_reset();
    test_single_packet();
    test_round_robin();
    test_backpressure();
    test_framing();
    test_reset_mid_packet();
    test_wrap();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
